// File: rtl/rv_imem_responder_pkg.sv
// Shared types and limits for the instruction-memory responder.
package rv_imem_responder_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_ACK  = 2'd2
    } imem_state_t;

    localparam int unsigned IMEM_WS_MAX = 15;

endpackage

// File: rtl/rv_imem_ram.sv
// Single-write, single-registered-read instruction RAM; a read and a write of the
// same word on one edge returns the old contents.
module rv_imem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [31:0]                    i_wdata,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rv_imem_responder.sv
// Fetch-bus responder: captures a word address, waits WAIT_STATES cycles while the
// request stays stable, then returns one registered ack with the RAM word or an error.
module rv_imem_responder
    import rv_imem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_cyc,
    input  logic [31:0]                    i_addr,
    output logic                           o_ack,
    output logic [31:0]                    o_instruction,
    output logic                           o_err,
    input  logic                           i_ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_ld_addr,
    input  logic [31:0]                    i_ld_data
);

    localparam int unsigned   AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned   CW   = $clog2(IMEM_WS_MAX + 1);
    localparam logic [CW-1:0] WS   = CW'(WAIT_STATES);
    localparam logic [31:0]   LO_W = {2'b00, BASE_ADDR[31:2]};

    imem_state_t   r_state;
    imem_state_t   w_state_next;
    logic [29:0]   r_req_addr;
    logic [CW-1:0] r_wait_cnt;
    logic          r_ack;
    logic          r_err;

    logic          w_addr_match;
    logic          w_capture;
    logic          w_enter_ack;
    logic          w_in_range;
    logic [29:0]   w_rd_word;
    logic [31:0]   w_offset;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_rd_data;
    logic          w_unused_addr_lsb;

    assign w_addr_match      = (i_addr[31:2] == r_req_addr);
    assign w_unused_addr_lsb = ^i_addr[1:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IMEM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IMEM_IDLE: begin
                if (i_cyc) begin
                    w_state_next = (WS == '0) ? IMEM_ACK : IMEM_WAIT;
                end
            end
            IMEM_WAIT: begin
                if (!i_cyc) begin
                    w_state_next = IMEM_IDLE;
                end else if (w_addr_match && (r_wait_cnt == CW'(1))) begin
                    w_state_next = IMEM_ACK;
                end
            end
            IMEM_ACK:  w_state_next = IMEM_IDLE;
            default:   w_state_next = IMEM_IDLE;
        endcase
    end

    always_comb begin
        w_capture   = i_cyc && ((r_state == IMEM_IDLE) ||
                                ((r_state == IMEM_WAIT) && !w_addr_match));
        w_enter_ack = (w_state_next == IMEM_ACK);
        // From IDLE with no wait states the address is read on the capture edge itself.
        w_rd_word   = (r_state == IMEM_IDLE) ? i_addr[31:2] : r_req_addr;
        // Below-base addresses wrap to a huge offset, so one unsigned compare covers both ends.
        w_offset    = {2'b00, w_rd_word} - LO_W;
        w_in_range  = (w_offset < 32'(DEPTH_WORDS));
        w_rd_idx    = w_offset[AW-1:0];

        o_ack         = r_ack;
        o_err         = r_err;
        o_instruction = (r_ack && !r_err) ? w_rd_data : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req_addr <= '0;
            r_wait_cnt <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ack <= w_enter_ack;
            r_err <= w_enter_ack && !w_in_range;
            if (w_capture) begin
                r_req_addr <= i_addr[31:2];
                r_wait_cnt <= WS;
            end else if (r_state == IMEM_WAIT) begin
                r_wait_cnt <= i_cyc ? (r_wait_cnt - CW'(1)) : '0;
            end else if (r_state == IMEM_ACK) begin
                r_wait_cnt <= '0;
            end
        end
    end

    rv_imem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (i_ld_we),
        .i_waddr(i_ld_addr),
        .i_wdata(i_ld_data),
        .i_re   (w_enter_ack),
        .i_raddr(w_rd_idx),
        .o_rdata(w_rd_data)
    );

endmodule

// File: tb/tb_rv_imem_responder.sv
// Bench for rv_imem_responder: four configurations side by side, a timestamp-based
// transaction model checked every cycle, plus directed literal expectations.
module tb_rv_imem_responder;

    localparam int unsigned N       = 4;
    localparam int unsigned WS_A    = 0;
    localparam int unsigned WS_B    = 3;
    localparam int unsigned WS_C    = 2;
    localparam int unsigned WS_D    = 1;
    localparam logic [31:0] BASE_D  = 32'h0000_1000;
    localparam longint      BASE_WD = 64'h400;
    localparam int unsigned DEPTH_D = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         cyc     = '0;
    logic [N-1:0]         ld_we   = '0;
    logic [N-1:0][31:0]   addr    = '0;
    logic [N-1:0][31:0]   ld_data = '0;
    logic [N-1:0][9:0]    ld_addr = '0;
    wire  [N-1:0]         ack;
    wire  [N-1:0]         err;
    wire  [N-1:0][31:0]   ins;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [31:0] mem_m   [N][1024];
    bit          pend    [N] = '{default: 1'b0};
    int          cap_e   [N] = '{default: 0};
    int          free_e  [N] = '{default: 0};
    logic [29:0] a_m     [N] = '{default: '0};
    logic        exp_ack [N] = '{default: 1'b0};
    logic        exp_err [N] = '{default: 1'b0};
    logic [31:0] exp_ins [N] = '{default: '0};
    string       nm      [N] = '{"a", "b", "c", "d"};

    always #5 clk = ~clk;

    rv_imem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(WS_A)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc[0]), .i_addr(addr[0]), .o_ack(ack[0]),
        .o_instruction(ins[0]), .o_err(err[0]), .i_ld_we(ld_we[0]), .i_ld_addr(ld_addr[0]),
        .i_ld_data(ld_data[0]));
    rv_imem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(WS_B)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc[1]), .i_addr(addr[1]), .o_ack(ack[1]),
        .o_instruction(ins[1]), .o_err(err[1]), .i_ld_we(ld_we[1]), .i_ld_addr(ld_addr[1]),
        .i_ld_data(ld_data[1]));
    rv_imem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(WS_C)) u_dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc[2]), .i_addr(addr[2]), .o_ack(ack[2]),
        .o_instruction(ins[2]), .o_err(err[2]), .i_ld_we(ld_we[2]), .i_ld_addr(ld_addr[2]),
        .i_ld_data(ld_data[2]));
    rv_imem_responder #(.BASE_ADDR(BASE_D), .DEPTH_WORDS(DEPTH_D), .WAIT_STATES(WS_D)) u_dut_d (
        .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc[3]), .i_addr(addr[3]), .o_ack(ack[3]),
        .o_instruction(ins[3]), .o_err(err[3]), .i_ld_we(ld_we[3]),
        .i_ld_addr(ld_addr[3][3:0]), .i_ld_data(ld_data[3]));

    function automatic int ws_of(int i);
        case (i)
            0:       return int'(WS_A);
            1:       return int'(WS_B);
            2:       return int'(WS_C);
            default: return int'(WS_D);
        endcase
    endfunction

    function automatic longint base_w_of(int i);
        return (i == 3) ? BASE_WD : 64'd0;
    endfunction

    function automatic longint depth_of(int i);
        return (i == 3) ? longint'(DEPTH_D) : 64'd1024;
    endfunction

    function automatic logic [31:0] pat(int i, int w);
        if (i == 0 && w == 0) return 32'h0000_0013;
        return 32'hC000_0000 | (32'(i) << 16) | 32'(w);
    endfunction

    // Request timeline in edge numbers: a captured word is answered WS edges after its
    // latest capture if it stays requested and unchanged; the next capture is 2 edges later.
    function automatic bit capture(int i);
        return !pend[i] && cyc[i] && (edge_n >= free_e[i]);
    endfunction

    function automatic bit aborting(int i);
        return pend[i] && !cyc[i];
    endfunction

    function automatic bit restart(int i);
        return pend[i] && cyc[i] && (addr[i][31:2] != a_m[i]);
    endfunction

    function automatic bit fires(int i);
        if (pend[i])
            return cyc[i] && (addr[i][31:2] == a_m[i]) && (edge_n == cap_e[i] + ws_of(i));
        return capture(i) && (ws_of(i) == 0);
    endfunction

    function automatic longint word_off(int i);
        return longint'(addr[i][31:2]) - base_w_of(i);
    endfunction

    function automatic bit in_range(int i);
        return (word_off(i) >= 0) && (word_off(i) < depth_of(i));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            exp_ack[i] <= 1'b0;
            exp_err[i] <= 1'b0;
            exp_ins[i] <= '0;
            if (!rst_n) begin
                pend[i]   <= 1'b0;
                free_e[i] <= edge_n + 1;
            end else if (fires(i)) begin
                pend[i]    <= 1'b0;
                free_e[i]  <= edge_n + 2;
                exp_ack[i] <= 1'b1;
                if (in_range(i)) exp_ins[i] <= mem_m[i][int'(word_off(i))];
                else             exp_err[i] <= 1'b1;
            end else if (aborting(i)) begin
                pend[i]   <= 1'b0;
                free_e[i] <= edge_n + 1;
            end else if (restart(i) || capture(i)) begin
                pend[i]  <= 1'b1;
                cap_e[i] <= edge_n;
                a_m[i]   <= addr[i][31:2];
            end
            if (ld_we[i]) mem_m[i][int'(longint'(ld_addr[i]) % depth_of(i))] <= ld_data[i];
        end
        edge_n <= edge_n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk({"ack_", nm[i]}, 32'(ack[i]), rst_n ? 32'(exp_ack[i]) : 32'd0);
            chk({"err_", nm[i]}, 32'(err[i]), rst_n ? 32'(exp_err[i]) : 32'd0);
            chk({"ins_", nm[i]}, ins[i], rst_n ? exp_ins[i] : 32'd0);
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        nxt();
        chk("reset_ack", 32'(ack[0]), 32'd0);
        chk("reset_ins", ins[0], 32'd0);
        chk("reset_err", 32'(err[0]), 32'd0);

        for (int w = 0; w < 1024; w++) begin
            nxt();
            for (int i = 0; i < N; i++) begin
                ld_we[i]   = (i < 3) || (w < 16);
                ld_addr[i] = 10'(w);
                ld_data[i] = pat(i, w);
            end
        end

        // Release reset and request on the same cycle: capture at the first free edge.
        nxt();
        ld_we = '0; rst_n = 1'b1; cyc[0] = 1'b1; addr[0] = 32'h0;
        nxt(); chk("t1_ack", 32'(ack[0]), 32'd1); chk("t1_ins", ins[0], 32'h0000_0013);
        chk("t1_err", 32'(err[0]), 32'd0); addr[0] = 32'h4;
        nxt(); chk("t1_gap", 32'(ack[0]), 32'd0);
        nxt(); chk("t1_ack2", 32'(ack[0]), 32'd1); chk("t1_ins2", ins[0], 32'hC000_0001);
        cyc[0] = 1'b0;
        nxt(); nxt();

        cyc[1] = 1'b1; addr[1] = 32'h8;
        for (int k = 0; k < 4; k++) begin
            nxt(); chk("t2_ack", 32'(ack[1]), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("t2_ins", ins[1], 32'hC001_0002); cyc[1] = 1'b0;
        nxt(); nxt();

        cyc[1] = 1'b1; addr[1] = 32'h0;
        nxt(); chk("t3_wait1", 32'(ack[1]), 32'd0);
        nxt(); chk("t3_wait2", 32'(ack[1]), 32'd0); cyc[1] = 1'b0;
        nxt(); chk("t3_abort", 32'(ack[1]), 32'd0); cyc[1] = 1'b1; addr[1] = 32'h4;
        for (int k = 0; k < 4; k++) begin
            nxt(); chk("t3_ack", 32'(ack[1]), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("t3_ins", ins[1], 32'hC001_0001); cyc[1] = 1'b0;
        nxt(); nxt();

        cyc[2] = 1'b1; addr[2] = 32'h0;
        nxt(); chk("t4_ack_c1", 32'(ack[2]), 32'd0); addr[2] = 32'h10;
        nxt(); chk("t4_ack_c2", 32'(ack[2]), 32'd0);
        nxt(); chk("t4_ack_c3", 32'(ack[2]), 32'd0);
        nxt(); chk("t4_ack_c4", 32'(ack[2]), 32'd1); chk("t4_ins", ins[2], 32'hC002_0004);
        cyc[2] = 1'b0;
        nxt(); chk("t4_single", 32'(ack[2]), 32'd0);
        nxt();

        cyc[3] = 1'b1; addr[3] = 32'h0000_1040;
        nxt(); chk("t5_wait", 32'(ack[3]), 32'd0);
        nxt(); chk("t5_hi_ack", 32'(ack[3]), 32'd1); chk("t5_hi_err", 32'(err[3]), 32'd1);
        chk("t5_hi_ins", ins[3], 32'd0); addr[3] = 32'h0000_0FFC;
        nxt(); nxt();
        nxt(); chk("t5_lo_ack", 32'(ack[3]), 32'd1); chk("t5_lo_err", 32'(err[3]), 32'd1);
        addr[3] = 32'h0000_103C;
        nxt(); nxt();
        nxt(); chk("t5_top_ack", 32'(ack[3]), 32'd1); chk("t5_top_err", 32'(err[3]), 32'd0);
        chk("t5_top_ins", ins[3], 32'hC003_000F); cyc[3] = 1'b0;
        nxt(); nxt();

        cyc[0] = 1'b1; addr[0] = 32'h14;
        ld_we[0] = 1'b1; ld_addr[0] = 10'd5; ld_data[0] = 32'hDEAD_BEEF;
        nxt(); ld_we[0] = 1'b0;
        chk("t6_old_ack", 32'(ack[0]), 32'd1); chk("t6_old_ins", ins[0], 32'hC000_0005);
        nxt();
        nxt(); chk("t6_new_ack", 32'(ack[0]), 32'd1); chk("t6_new_ins", ins[0], 32'hDEAD_BEEF);
        cyc[0] = 1'b0;
        nxt(); nxt();

        cyc[0] = 1'b1; addr[0] = 32'h0; cyc[1] = 1'b1; addr[1] = 32'hC;
        nxt(); chk("t7_pre_ack_a", 32'(ack[0]), 32'd1); chk("t7_pre_ack_b", 32'(ack[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_ack_a", 32'(ack[0]), 32'd0); chk("t7_rst_ins_a", ins[0], 32'd0);
        chk("t7_rst_err_a", 32'(err[0]), 32'd0); chk("t7_rst_ack_b", 32'(ack[1]), 32'd0);
        nxt(); nxt();
        rst_n = 1'b1; cyc[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nxt(); chk("t7_post_ack", 32'(ack[1]), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("t7_post_ins", ins[1], 32'hC001_0003); cyc[1] = 1'b0;
        nxt(); nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_imem_responder.md
# rv_imem_responder

Instruction-bus responder that answers the core fetch stage's requests (`i_cyc`/`i_addr` in, `o_ack`/`o_instruction` out) from a local word-addressed instruction RAM with a configurable number of wait states. It sits on the far side of the fetch interface: in simulation top-levels and small FPGA builds it replaces external instruction memory. A side loader port lets a testbench or boot block write program words.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥2.
- `WAIT_STATES`, 0: extra cycles between address capture and ack; 0..15.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_cyc`  in  1  fetch request valid; held by the initiator until ack.
- `i_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `o_ack`  out  1  one-cycle response strobe, registered.
- `o_instruction`  out  32  response word; valid only while `o_ack`=1, else 0.
- `o_err`  out  1  with `o_ack`: address outside [BASE_ADDR, BASE_ADDR+4·DEPTH_WORDS).
- `i_ld_we`  in  1  loader write enable.
- `i_ld_addr`  in  $clog2(DEPTH_WORDS)  loader word index.
- `i_ld_data`  in  32  loader write data.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: if `i_cyc`, capture `i_addr[31:2]` into `req_addr`, load `wait_cnt`=WAIT_STATES; go to WAIT if WAIT_STATES>0, else ACK.
- WAIT: decrement `wait_cnt`. If `i_cyc`=0, abort to IDLE, no ack. If `i_addr[31:2]`≠`req_addr`, recapture the new address, reload `wait_cnt`, stay in WAIT (restart). When `wait_cnt`=1 and no abort or restart, go to ACK.
- Data read: registered at the edge entering ACK, using `req_addr`. In range: `o_instruction`=RAM[(req_addr − BASE_ADDR[31:2]) mod DEPTH_WORDS], `o_err`=0. Out of range: `o_instruction`=0, `o_err`=1.
- ACK: `o_ack`=1 for exactly one cycle. `i_addr` is not sampled in ACK because the initiator's PC has not advanced yet. Next state is IDLE unconditionally, even if `i_cyc` dropped.
- Range check uses 32-bit unsigned compare on word addresses. No wrap-around past 2^32; BASE_ADDR+4·DEPTH_WORDS must not overflow.
- Loader write: RAM[i_ld_addr] ← i_ld_data at the edge when `i_ld_we`=1. Allowed in any state.
  - Read and write of the same word on the same edge: read returns old data.
  - A write earlier than the ACK-entry edge is visible in the response.
- RAM contents are not reset.

## Timing
- Reset (asynchronous assert): state=IDLE, `wait_cnt`=0, `o_ack`=0, `o_instruction`=0, `o_err`=0, immediately. Any in-flight request is dropped with no ack.
- Latency: `i_cyc` seen at edge k (IDLE) → `o_ack` high during cycle k+1+WAIT_STATES.
- Back-to-back throughput: one response per 2+WAIT_STATES cycles (IDLE capture, wait, ACK).
- `o_ack`, `o_instruction`, `o_err` are all flop outputs with no combinational path from the inputs.
- Reset deassertion: first capture is possible at the first edge with `i_reset_n`=1.

## Structure
- Shared package holds the `imem_state_t` enum (IMEM_IDLE, IMEM_WAIT, IMEM_ACK) and the `IMEM_WS_MAX`=15 constant.
- Sub-module `rv_imem_ram` contains the RAM: one write port and one registered read port with read-before-write behaviour. It is inferable as block RAM.
- Top module contains the FSM, wait counter, range check and output registers.

## Test plan
- WAIT_STATES=0, RAM[0]=32'h0000_0013, `i_cyc`=1, `i_addr`=0 at edge 0 → `o_ack`=1 and `o_instruction`=32'h0000_0013 in cycle 1; `o_ack`=0 in cycle 2; next capture at edge 2.
- WAIT_STATES=3, `i_addr`=0x8 held → `o_ack` only in cycle 4, with RAM[2].
- WAIT_STATES=3, `i_cyc` dropped in cycle 2 → no ack. A new request at 0x4 acks with RAM[1] after the full 3-cycle wait.
- WAIT_STATES=2, `i_addr` changes 0x0→0x10 in cycle 1 → single ack in cycle 4 carrying RAM[4]; no ack for 0x0.
- BASE_ADDR=0x1000, DEPTH_WORDS=16, request at 0x1040 → `o_ack`=1, `o_err`=1, `o_instruction`=0. Request at 0x0FFC also returns `o_err`=1.
- Loader write RAM[5]=0xDEADBEEF on the same edge as ACK entry for word 5 → old value returned; a repeat fetch returns 0xDEADBEEF. Reset asserted mid-WAIT → `o_ack` stays 0 and all outputs read 0 immediately.
